mul_exec_pipe: RTL and testbench

- Fixed-latency, 5-stage multiply execution pipeline, sitting between decode and write-back.
- Accepts multiply ops issued by decode when the decode stall is low.
- Carries each op's valid bit and destination register through stages ex1..ex5 and writes the result back from ex5.
- Its per-stage valid/destination outputs and its write-back-next-cycle flag feed the hazard unit directly; the hazard unit uses them for RAW detection and write-port collision avoidance.

---
 rtl/mul_exec_pipe.sv | 107 ++++++++++
 tb/tb_mul_exec_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_exec_pipe.sv
// mul_exec_pipe: 5-stage fixed-latency multiply pipe (ex1..ex5) with write-back from ex5.
// Optional perf counters are enabled with `define MUL_EXEC_PIPE_PERF_EN.
module mul_exec_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      issue_valid_i,
    input  logic [1:0]                issue_op_i,
    input  logic [REGISTER_WIDTH-1:0] issue_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]     issue_a_i,
    input  logic [DATA_WIDTH-1:0]     issue_b_i,
    input  logic                      stall_ex_i,
    input  logic                      flush_i,
    output logic                      ex1_valid_o,
    output logic                      ex2_valid_o,
    output logic                      ex3_valid_o,
    output logic                      ex4_valid_o,
    output logic                      ex5_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic                      wb_is_next_cycle_o,
    output logic                      wb_we_o,
    output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o
`ifdef MUL_EXEC_PIPE_PERF_EN
    ,
    output logic [31:0]               perf_issued_o,
    output logic [31:0]               perf_stall_o
`endif
);
    localparam int DW = DATA_WIDTH;

    logic [4:0]                v_q, v_d;
    logic [REGISTER_WIDTH-1:0] rd_q [5];
    logic [DW-1:0]             res_q [4];
    logic [1:0]                op_q;
    logic [DW-1:0]             a_q, b_q;
    logic signed [DW:0]        ae, be;
    logic signed [2*DW-1:0]    prod;
    logic [DW-1:0]             res_d;

    // Operands widen by one bit so a single signed multiply serves all four ops.
    always_comb begin
        ae    = $signed({(op_q == 2'd1 || op_q == 2'd2) & a_q[DW-1], a_q});
        be    = $signed({(op_q == 2'd1) & b_q[DW-1], b_q});
        prod  = $signed({{(DW-1){ae[DW]}}, ae}) * $signed({{(DW-1){be[DW]}}, be});
        res_d = (op_q == 2'd0) ? prod[DW-1:0] : prod[2*DW-1:DW];
        v_d   = flush_i ? 5'b0 : stall_ex_i ? v_q : {v_q[3:0], issue_valid_i};
    end

    always_ff @(posedge clk_i) begin
        if (!stall_ex_i) begin
            op_q <= issue_op_i;
            a_q  <= issue_a_i;
            b_q  <= issue_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int k = 0; k < 5; k++) rd_q[k] <= '0;
            for (int k = 0; k < 4; k++) res_q[k] <= '0;
        end else begin
            v_q <= v_d;
            if (!stall_ex_i) begin
                rd_q[0]  <= issue_wr_reg_i;
                res_q[0] <= res_d;
                for (int k = 1; k < 5; k++) rd_q[k] <= rd_q[k-1];
                for (int k = 1; k < 4; k++) res_q[k] <= res_q[k-1];
            end
        end
    end

    assign ex1_valid_o        = v_q[0];
    assign ex2_valid_o        = v_q[1];
    assign ex3_valid_o        = v_q[2];
    assign ex4_valid_o        = v_q[3];
    assign ex5_valid_o        = v_q[4];
    assign ex1_wr_reg_o       = rd_q[0];
    assign ex2_wr_reg_o       = rd_q[1];
    assign ex3_wr_reg_o       = rd_q[2];
    assign ex4_wr_reg_o       = rd_q[3];
    assign wb_wr_reg_o        = rd_q[4];
    assign wb_data_o          = res_q[3];
    assign wb_we_o            = v_q[4] && !stall_ex_i && (rd_q[4] != '0);
    assign wb_is_next_cycle_o = v_q[3] && !stall_ex_i && !flush_i;

`ifdef MUL_EXEC_PIPE_PERF_EN
    logic [31:0] iss_q, stl_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_q <= '0;
            stl_q <= '0;
        end else begin
            if (issue_valid_i && !stall_ex_i && !flush_i) iss_q <= iss_q + 32'd1;
            if (stall_ex_i && (v_q != '0)) stl_q <= stl_q + 32'd1;
        end
    end
    assign perf_issued_o = iss_q;
    assign perf_stall_o  = stl_q;
`endif
endmodule

// File: tb/tb_mul_exec_pipe.sv
// tb_mul_exec_pipe: directed + random checks of mul_exec_pipe against an in-flight op list model.
module tb_mul_exec_pipe;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic [1:0]  issue_op_i;
    logic [4:0]  issue_wr_reg_i;
    logic [31:0] issue_a_i, issue_b_i;
    logic        stall_ex_i, flush_i;
    logic        ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o;
    logic [4:0]  ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o;
    logic        wb_is_next_cycle_o, wb_we_o;
    logic [4:0]  wb_wr_reg_o;
    logic [31:0] wb_data_o;
`ifdef MUL_EXEC_PIPE_PERF_EN
    logic [31:0] perf_issued_o, perf_stall_o;
`endif

    mul_exec_pipe dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_op_i(issue_op_i), .issue_wr_reg_i(issue_wr_reg_i),
        .issue_a_i(issue_a_i), .issue_b_i(issue_b_i),
        .stall_ex_i(stall_ex_i), .flush_i(flush_i),
        .ex1_valid_o(ex1_valid_o), .ex2_valid_o(ex2_valid_o), .ex3_valid_o(ex3_valid_o),
        .ex4_valid_o(ex4_valid_o), .ex5_valid_o(ex5_valid_o),
        .ex1_wr_reg_o(ex1_wr_reg_o), .ex2_wr_reg_o(ex2_wr_reg_o),
        .ex3_wr_reg_o(ex3_wr_reg_o), .ex4_wr_reg_o(ex4_wr_reg_o),
        .wb_is_next_cycle_o(wb_is_next_cycle_o), .wb_we_o(wb_we_o),
        .wb_wr_reg_o(wb_wr_reg_o), .wb_data_o(wb_data_o)
`ifdef MUL_EXEC_PIPE_PERF_EN
        , .perf_issued_o(perf_issued_o), .perf_stall_o(perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          stage;
        logic [4:0]  rd;
        logic [31:0] res;
    } op_t;

    op_t         inflight[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_issued = 0, exp_stall = 0;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = (op == 2'd1 || op == 2'd2) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (op == 2'd1) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = 64'(sa * sb);
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int find(input int s);
        foreach (inflight[i]) if (inflight[i].stage == s) return i;
        return -1;
    endfunction

    function automatic logic [5:0] dut_stage(input int n);
        case (n)
            1: return {ex1_valid_o, ex1_wr_reg_o};
            2: return {ex2_valid_o, ex2_wr_reg_o};
            3: return {ex3_valid_o, ex3_wr_reg_o};
            4: return {ex4_valid_o, ex4_wr_reg_o};
            default: return {ex5_valid_o, wb_wr_reg_o};
        endcase
    endfunction

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, e);
        end
    endtask

    task automatic check_all();
        int i;
        logic [5:0] s;
        for (int n = 1; n <= 5; n++) begin
            i = find(n);
            s = dut_stage(n);
            chk($sformatf("ex%0d_valid", n), 64'(s[5]), 64'(i >= 0));
            if (i >= 0) chk($sformatf("ex%0d_rd", n), 64'(s[4:0]), 64'(inflight[i].rd));
        end
        i = find(5);
        chk("wb_we", 64'(wb_we_o), 64'(i >= 0 && !stall_ex_i && inflight[i].rd != 0));
        if (i >= 0) chk("wb_data", 64'(wb_data_o), 64'(inflight[i].res));
        chk("wb_next", 64'(wb_is_next_cycle_o), 64'(find(4) >= 0 && !stall_ex_i && !flush_i));
`ifdef MUL_EXEC_PIPE_PERF_EN
        chk("perf_issued", 64'(perf_issued_o), 64'(exp_issued));
        chk("perf_stall", 64'(perf_stall_o), 64'(exp_stall));
`endif
    endtask

    // Drive one cycle of inputs, check, then advance the model across the edge.
    task automatic cyc(input logic iv, input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic st, input logic fl);
        op_t o;
        issue_valid_i = iv; issue_op_i = op; issue_wr_reg_i = rd;
        issue_a_i = a; issue_b_i = b; stall_ex_i = st; flush_i = fl;
        #1;
        check_all();
        @(posedge clk_i);
        if (st && inflight.size() > 0) exp_stall++;
        if (fl) inflight.delete();
        else if (!st) begin
            foreach (inflight[i]) inflight[i].stage++;
            while (inflight.size() > 0 && inflight[0].stage > 5) void'(inflight.pop_front());
            if (iv) begin
                o.stage = 1; o.rd = rd; o.res = ref_mul(op, a, b);
                inflight.push_back(o);
                exp_issued++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic reset_outputs_check();
        chk("rst_valids", 64'({ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o}), 64'd0);
        chk("rst_rds", 64'({ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o, wb_wr_reg_o}), 64'd0);
        chk("rst_we", 64'(wb_we_o), 64'd0);
        chk("rst_data", 64'(wb_data_o), 64'd0);
`ifdef MUL_EXEC_PIPE_PERF_EN
        chk("rst_perf", 64'({perf_issued_o, perf_stall_o}), 64'd0);
`endif
    endtask

    logic [1:0]  hv_op [5] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] hv_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] hv_b  [5] = '{32'd2, 32'd2, 32'd2, 32'h80000000, 32'h80000000};
    logic [31:0] hv_e  [5] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h40000000};

    initial begin
        logic [31:0] ra, rb;
        rst_ni = 1'b0; issue_valid_i = 0; issue_op_i = 0; issue_wr_reg_i = 0;
        issue_a_i = 0; issue_b_i = 0; stall_ex_i = 0; flush_i = 0;
        #12;
        reset_outputs_check();
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Single MUL 7*6 -> x3
        cyc(1'b1, 2'd0, 5'd3, 32'd7, 32'd6, 1'b0, 1'b0);
        idle(3);
        chk("single_wb_next", 64'(wb_is_next_cycle_o), 64'd1);
        idle(1);
        chk("single_we", 64'(wb_we_o), 64'd1);
        chk("single_rd", 64'(wb_wr_reg_o), 64'd3);
        chk("single_data", 64'(wb_data_o), 64'd42);
        idle(1);

        // High-half variants
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, hv_op[k], 5'd9, hv_a[k], hv_b[k], 1'b0, 1'b0);
            idle(4);
            chk($sformatf("hv%0d_data", k), 64'(wb_data_o), 64'(hv_e[k]));
        end
        idle(1);

        // Back-to-back rd=1..5
        for (int k = 1; k <= 5; k++) cyc(1'b1, 2'd0, 5'(k), 32'(k), 32'd3, 1'b0, 1'b0);
        chk("b2b_all_valid", 64'({ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o}), 64'h1F);
        idle(6);

        // Stall in cycles 2-3
        cyc(1'b1, 2'd3, 5'd7, 32'd100, 32'd5, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 5'd8, 32'd1, 32'd1, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 5'd8, 32'd1, 32'd1, 1'b1, 1'b0);
        chk("stall_held_ex2", 64'({ex2_valid_o, ex2_wr_reg_o}), 64'({1'b1, 5'd7}));
        idle(2);
        chk("stall_ex4", 64'(ex4_valid_o), 64'd1);
        idle(1);
        chk("stall_wb_slip", 64'({wb_we_o, wb_wr_reg_o}), 64'({1'b1, 5'd7}));
        idle(1);

        // Flush with concurrent issue, also while stalled
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'd1, 5'(10 + k), 32'(k + 2), 32'hFFFFFFF0, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 5'd20, 32'd5, 32'd5, 1'b1, 1'b1);
        chk("flush_valids", 64'({ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o}), 64'd0);
        idle(6);

        // Asynchronous reset mid-cycle
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'd2, 5'(k + 1), 32'hDEAD0000, 32'(k), 1'b0, 1'b0);
        #3 rst_ni = 1'b0;
        #1 reset_outputs_check();
        inflight.delete(); exp_issued = 0; exp_stall = 0;
        #2 rst_ni = 1'b1;
        idle(6);

        // x0 destination
        cyc(1'b1, 2'd0, 5'd0, 32'd9, 32'd9, 1'b0, 1'b0);
        idle(4);
        chk("x0_ex5_valid", 64'(ex5_valid_o), 64'd1);
        chk("x0_we", 64'(wb_we_o), 64'd0);
        idle(1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            cyc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                ra, rb, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
